// File: rtl/instruction_fetch_stage_pkg.sv
// Shared CPU definitions: instruction encodings, fetch reset/bubble values,
// redirect-source encoding and small PC helpers used by the fetch stage.
package cpu_defs;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    // sll $0,$0,0 -- all-zero so jump detection downstream sees nothing
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR  = 6'h08;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_JUMP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_JR     = 2'd3
    } redirect_src_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall requests in, instruction memory port,
// and the IF/ID pipeline register contents out.
interface instruction_fetch_stage_if;

    logic        stall;
    logic        doesJump;
    logic [31:0] jumpAddress;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jrTaken;
    logic [31:0] jrTarget;
    logic [31:0] imemData;
    logic [31:0] imemAddr;
    logic [31:0] ifidInstruction;
    logic [31:0] ifidPcPlus4;
    logic        ifidValid;
    logic        misalignFault;

    // master is the fetch stage itself; slave is the rest of the pipeline/memory
    modport master (
        input  stall, doesJump, jumpAddress, branchTaken, branchTarget,
               jrTaken, jrTarget, imemData,
        output imemAddr, ifidInstruction, ifidPcPlus4, ifidValid, misalignFault
    );

    modport slave (
        output stall, doesJump, jumpAddress, branchTaken, branchTarget,
               jrTaken, jrTarget, imemData,
        input  imemAddr, ifidInstruction, ifidPcPlus4, ifidValid, misalignFault
    );

endinterface

// File: rtl/instruction_fetch_stage_pc_next_select.sv
// Next-PC priority mux: the oldest in-flight redirect wins (JR, then branch,
// then ID jump); with no redirect the PC advances or holds on a stall.
module pc_next_select
    import cpu_defs::*;
(
    input  logic [31:0]   pc,
    input  logic          stall,
    input  logic          doesJump,
    input  logic [31:0]   jumpAddress,
    input  logic          branchTaken,
    input  logic [31:0]   branchTarget,
    input  logic          jrTaken,
    input  logic [31:0]   jrTarget,
    output logic [31:0]   next_pc,
    output logic          redirect,
    output redirect_src_e source
);

    always_comb begin
        next_pc  = pc + 32'd4;
        redirect = 1'b0;
        source   = SRC_SEQ;
        if (jrTaken) begin
            next_pc  = word_align(jrTarget);
            redirect = 1'b1;
            source   = SRC_JR;
        end else if (branchTaken) begin
            next_pc  = word_align(branchTarget);
            redirect = 1'b1;
            source   = SRC_BRANCH;
        end else if (doesJump && !stall) begin
            // a stalled jump is re-presented when ID advances, so it redirects once
            next_pc  = word_align(jumpAddress);
            redirect = 1'b1;
            source   = SRC_JUMP;
        end else if (stall) begin
            next_pc  = pc;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: program counter, IF/ID pipeline register and sticky JR
// misalignment flag, steered by pc_next_select.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = cpu_defs::RESET_PC,
    parameter logic [31:0] NOP_INSTR = cpu_defs::NOP_INSTR
) (
    input logic                         clk,
    input logic                         resetN,
    instruction_fetch_stage_if.master   bus
);
    import cpu_defs::*;

    logic [31:0]   pc;
    logic [31:0]   next_pc;
    logic          redirect;
    redirect_src_e source;

    logic [31:0]   ifid_instr;
    logic [31:0]   ifid_pc_plus4;
    logic          ifid_valid;
    logic          fault;

    pc_next_select u_pc_next_select (
        .pc           (pc),
        .stall        (bus.stall),
        .doesJump     (bus.doesJump),
        .jumpAddress  (bus.jumpAddress),
        .branchTaken  (bus.branchTaken),
        .branchTarget (bus.branchTarget),
        .jrTaken      (bus.jrTaken),
        .jrTarget     (bus.jrTarget),
        .next_pc      (next_pc),
        .redirect     (redirect),
        .source       (source)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Any redirect squashes the slot being fetched; EX redirects beat a stall
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else if (redirect) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= 32'h0;
            ifid_valid    <= 1'b0;
        end else if (!bus.stall) begin
            ifid_instr    <= bus.imemData;
            ifid_pc_plus4 <= pc + 32'd4;
            ifid_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fault <= 1'b0;
        end else if (source == SRC_JR && is_misaligned(bus.jrTarget[1:0])) begin
            fault <= 1'b1;
        end
    end

    assign bus.imemAddr        = pc;
    assign bus.ifidInstruction = ifid_instr;
    assign bus.ifidPcPlus4     = ifid_pc_plus4;
    assign bus.ifidValid       = ifid_valid;
    assign bus.misalignFault   = fault;

endmodule
